// File: rtl/sqrt_pkg.sv
// Shared types and defaults for the iterative integer square-root block.
package sqrt_pkg;

  localparam int unsigned SQRT_SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIter = 2'b01,
    StDone = 2'b10
  } sqrt_state_e;

endpackage

// File: rtl/first_one_finder.sv
// Returns the largest power of four that is <= i_number (zero when i_number is zero).
module first_one_finder #(
  parameter int unsigned SIZE = 32
) (
  input  logic [SIZE-1:0] i_number,
  output logic [SIZE-1:0] o_pow4,
  output logic            o_found
);

  // Scan bit pairs upward so the highest non-zero pair wins.
  always_comb begin
    o_pow4  = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < SIZE / 2; i++) begin
      if (i_number[2*i +: 2] != 2'b00) begin
        o_pow4      = '0;
        o_pow4[2*i] = 1'b1;
        o_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/integer_sqrt_iter.sv
// Iterative digit-by-digit integer square root: one result bit per clock in ITER.
module integer_sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int unsigned SIZE = SQRT_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   number,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE/2-1:0] root,
  output logic [SIZE/2:0]   remainder
);

  localparam int unsigned HALF = SIZE / 2;

  sqrt_state_e r_state;
  sqrt_state_e w_state_next;

  logic [SIZE-1:0] r_num;
  logic [SIZE-1:0] r_res;
  logic [SIZE-1:0] r_bit;
  logic [HALF-1:0] r_root;
  logic [HALF:0]   r_rem;

  logic [SIZE-1:0] w_pow4;
  logic            w_found;
  logic            w_accept;
  logic            w_last;
  logic [SIZE:0]   w_sum;
  logic            w_ge;
  logic [SIZE-1:0] w_num_next;
  logic [SIZE-1:0] w_res_next;
  logic [SIZE-1:0] w_bit_next;

  first_one_finder #(
    .SIZE (SIZE)
  ) u_first_one_finder (
    .i_number (number),
    .o_pow4   (w_pow4),
    .o_found  (w_found)
  );

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_bit == SIZE'(1));

  // Single step unit; the compare is one bit wider so res + bit never wraps.
  always_comb begin
    w_sum      = {1'b0, r_res} + {1'b0, r_bit};
    w_ge       = ({1'b0, r_num} >= w_sum);
    w_num_next = r_num;
    w_res_next = r_res >> 1;
    if (w_ge) begin
      w_num_next = r_num - w_sum[SIZE-1:0];
      w_res_next = (r_res >> 1) + r_bit;
    end
    w_bit_next = r_bit >> 2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_found ? StIter : StDone;
        end
      end
      StIter: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_res  <= '0;
      r_bit  <= '0;
      r_root <= '0;
      r_rem  <= '0;
    end else begin
      if (w_accept) begin
        r_num <= number;
        r_res <= '0;
        r_bit <= w_pow4;
        if (!w_found) begin
          r_root <= '0;
          r_rem  <= '0;
        end
      end else if (r_state == StIter) begin
        r_num <= w_num_next;
        r_res <= w_res_next;
        r_bit <= w_bit_next;
        if (w_last) begin
          r_root <= w_res_next[HALF-1:0];
          r_rem  <= w_num_next[HALF:0];
        end
      end
    end
  end

  assign root      = r_root;
  assign remainder = r_rem;

endmodule

// File: doc/integer_sqrt_iter.md
INTEGER_SQRT_ITER -- requirements
Module: integer_sqrt_iter

Interface
REQ-001 SHALL have parameter SIZE, default 32, radicand width; even, >= 4.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  radicand offered.
REQ-005 SHALL have in_ready  output  1  block can accept a radicand.
REQ-006 SHALL have number  input  SIZE  unsigned radicand, sampled on accept.
REQ-007 SHALL have out_valid  output  1  result available.
REQ-008 SHALL have out_ready  input  1  consumer takes result.
REQ-009 SHALL have root  output  SIZE/2  floor(sqrt(number)).
REQ-010 SHALL have remainder  output  SIZE/2+1  number - root*root.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ITER, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-013 On accept SHALL load: num_r = number, res_r = 0, bit_r = largest power of 4 <= number (0 when number = 0).
REQ-014 On accept SHALL go to ITER if number != 0, else to DONE with root = 0, remainder = 0.
REQ-015 Each ITER edge SHALL perform one step: if num_r >= res_r + bit_r then num_r -= res_r + bit_r and res_r = (res_r >> 1) + bit_r; else res_r = res_r >> 1; then bit_r = bit_r >> 2.
REQ-016 Step arithmetic SHALL be SIZE+1 bits wide; no truncation of the res_r + bit_r compare.
REQ-017 ITER SHALL go to DONE on the edge where bit_r == 1 is processed; root/remainder SHALL be registered on that edge.
REQ-018 Latency: for number with leading power 4^k, out_valid SHALL rise k+1 edges after the accept edge; for number = 0, immediately after the accept edge. Max is SIZE/2 edges.
REQ-019 out_valid SHALL be 1 only in DONE; root and remainder SHALL hold stable while out_valid = 1.
REQ-020 On out_valid & out_ready SHALL return to IDLE; no new accept in the same cycle.
REQ-021 in_valid during ITER/DONE SHALL be ignored; number changes outside the accept edge SHALL have no effect.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 root and remainder SHALL keep their last values in IDLE and ITER.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, in_ready 1, out_valid 0, root 0, remainder 0, num_r/res_r/bit_r 0.
REQ-025 Reset asserted mid-ITER or in DONE SHALL discard the operation; no out_valid for it after release.
REQ-026 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package sqrt_pkg SHALL hold the FSM state type and the default SIZE constant.
REQ-028 The leading power-of-4 detection SHALL be an instance of first_one_finder (SIZE passed through) on number; no other sub-modules.
REQ-029 The datapath SHALL be one step unit reused every ITER cycle; no unrolled array.

Verification
REQ-030 number=0 -> out_valid right after accept edge, root 0, remainder 0.
REQ-031 number=1 -> root 1, remainder 0, latency 1; number=15 -> root 3, remainder 6, latency 2; number=16 -> root 4, remainder 0, latency 3.
REQ-032 number=32'hFFFFFFFF -> root 65535, remainder 131070, latency 16.
REQ-033 Result with out_ready low for 5 cycles -> out_valid, root, remainder stable, in_ready 0; in_valid toggling ignored; IDLE after the out_ready edge.
REQ-034 rst_n pulsed low at ITER step 3 of number=1000000 -> outputs 0 at once; next number=144 -> root 12, remainder 0.
REQ-035 10000 random numbers with random in_valid/out_ready gaps -> each root^2 <= number < (root+1)^2 and remainder exact.
